// File: rtl/reg_serializer_tx_clkneg_8bit_pkg.sv
// Shared constants for the negedge serializer: FSM state encodings and a
// width helper for counters.
package reg_serializer_tx_clkneg_8bit_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_DATA  = 2'b10;
  localparam logic [1:0] ST_STOP  = 2'b11;

  // ceil(log2(v)), never below 1 so a counter always has at least one bit
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bit_period_timer_clkneg.sv
// Negedge bit-period down-counter; o_tick marks the last cycle of each
// BIT_CYCLES-long period while running.
module bit_period_timer_clkneg
  import reg_serializer_tx_clkneg_8bit_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic Clk,
  input  logic Resetbar,
  input  logic i_restart,
  input  logic i_run,
  output logic o_tick
);

  localparam int            CW     = clog2_min1(BIT_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(negedge Clk) begin
    if (!Resetbar)
      r_cnt <= '0;
    else if (i_restart)
      r_cnt <= RELOAD;
    else if (i_run)
      r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - CW'(1);
  end

  assign o_tick = i_run && (r_cnt == '0);

endmodule

// File: rtl/reg_serializer_tx_clkneg_8bit.sv
// Serial transmit end of the negedge 8-bit register family: captures a byte
// on Loadbar low and sends start bit, WIDTH data bits, stop bit.
module reg_serializer_tx_clkneg_8bit
  import reg_serializer_tx_clkneg_8bit_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic             Clk,
  input  logic             Resetbar,
  input  logic [WIDTH-1:0] in,
  input  logic             Loadbar,
  output logic             Sout,
  output logic             Busy,
  output logic             Done
);

  localparam int            IW       = clog2_min1(WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [IW-1:0]    r_bit_idx;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;

  logic             w_load;
  logic             w_tick;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shifted;

  // Loads are only seen in IDLE, so a strobe during a frame is simply dropped
  assign w_load     = (r_state == ST_IDLE) && !Loadbar;
  assign w_next_bit = (LSB_FIRST != 0) ? r_shift[0] : r_shift[WIDTH-1];
  assign w_shifted  = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);

  bit_period_timer_clkneg #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .Clk      (Clk),
    .Resetbar (Resetbar),
    .i_restart(w_load),
    .i_run    (r_busy),
    .o_tick   (w_tick)
  );

  always_ff @(negedge Clk) begin
    if (!Resetbar) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_sout    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_shift   <= in;
            r_bit_idx <= '0;
            r_sout    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_sout    <= w_next_bit;
            r_shift   <= w_shifted;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_BIT) begin
              r_sout  <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_sout    <= w_next_bit;
              r_shift   <= w_shifted;
              r_bit_idx <= r_bit_idx + IW'(1);
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Sout = r_sout;
  assign Busy = r_busy;
  assign Done = r_done;

endmodule

// File: tb/tb_reg_serializer_tx_clkneg_8bit.sv
// Directed bench: each driven cycle pushes the expected {Sout,Busy,Done}
// frame into a per-DUT queue which is popped after every negedge.
module tb_reg_serializer_tx_clkneg_8bit;

  logic       clk;
  logic       rstb;
  logic [7:0] in0, in1;
  logic       lb0, lb1;
  logic       sout0, busy0, done0;
  logic       sout1, busy1, done1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int busy_n0, done_n0;

  logic [2:0] q0[$];
  logic [2:0] q1[$];
  logic       h0[$];
  logic       h1[$];

  reg_serializer_tx_clkneg_8bit dut0 (
    .Clk(clk), .Resetbar(rstb), .in(in0), .Loadbar(lb0),
    .Sout(sout0), .Busy(busy0), .Done(done0)
  );

  reg_serializer_tx_clkneg_8bit #(.WIDTH(8), .BIT_CYCLES(1), .LSB_FIRST(0)) dut1 (
    .Clk(clk), .Resetbar(rstb), .in(in1), .Loadbar(lb1),
    .Sout(sout1), .Busy(busy1), .Done(done1)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // dut0: 4 cycles/bit LSB first; dut1: 1 cycle/bit MSB first
  function automatic void push_frame(input bit which, input logic [7:0] d);
    logic [2:0] f[$];
    int   b;
    logic bv;
    b = which ? 1 : 4;
    for (int k = 0; k < b; k++) f.push_back(3'b010);
    for (int i = 0; i < 8; i++) begin
      bv = which ? d[7-i] : d[i];
      for (int k = 0; k < b; k++) f.push_back({bv, 2'b10});
    end
    for (int k = 0; k < b; k++) f.push_back(3'b110);
    f.push_back(3'b101);
    foreach (f[i]) begin
      if (which) q1.push_back(f[i]);
      else       q0.push_back(f[i]);
    end
  endfunction

  task automatic step(input logic rb, input logic l0, input logic [7:0] d0,
                      input logic l1, input logic [7:0] d1);
    logic [2:0] e0, e1;
    rstb = rb; lb0 = l0; in0 = d0; lb1 = l1; in1 = d1;
    if (!rb) begin
      q0.delete();
      q1.delete();
    end else begin
      if (!l0 && q0.size() == 0) push_frame(1'b0, d0);
      if (!l1 && q1.size() == 0) push_frame(1'b1, d1);
    end
    @(negedge clk);
    #1;
    cyc++;
    e0 = (q0.size() != 0) ? q0.pop_front() : 3'b100;
    e1 = (q1.size() != 0) ? q1.pop_front() : 3'b100;
    tests++;
    assert ({sout0, busy0, done0} === e0) else begin
      fails++;
      $error("FAIL dut0_cycle %0d: got %b expected %b", cyc, {sout0, busy0, done0}, e0);
    end
    tests++;
    assert ({sout1, busy1, done1} === e1) else begin
      fails++;
      $error("FAIL dut1_cycle %0d: got %b expected %b", cyc, {sout1, busy1, done1}, e1);
    end
    h0.push_back(sout0);
    h1.push_back(sout1);
    busy_n0 += int'(busy0);
    done_n0 += int'(done0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    logic [9:0] seq_a5, seq_0f, seq_80;
    seq_a5 = 10'b0101001011;
    seq_0f = 10'b0111100001;
    seq_80 = 10'b0100000001;
    rstb = 1'b0; lb0 = 1'b1; lb1 = 1'b1; in0 = 8'h00; in1 = 8'h00;
    busy_n0 = 0; done_n0 = 0;

    // reset overrides a held load
    step(1'b0, 1'b0, 8'hFF, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 8'hFF, 1'b0, 8'hFF);
    idle(3);

    // basic A5 frame
    h0.delete(); busy_n0 = 0; done_n0 = 0;
    step(1'b1, 1'b0, 8'hA5, 1'b1, 8'h00);
    idle(44);
    for (int i = 0; i < 10; i++) chk("basic_bit", int'(h0[i*4]), int'(seq_a5[9-i]));
    chk("basic_busy_cycles", busy_n0, 40);
    chk("basic_done_pulses", done_n0, 1);

    // load while busy at cycle 12, then back-to-back 0F in the Done cycle
    h0.delete(); busy_n0 = 0; done_n0 = 0;
    step(1'b1, 1'b0, 8'hA5, 1'b1, 8'h00);
    for (int k = 1; k <= 40; k++)
      step(1'b1, (k == 12) ? 1'b0 : 1'b1, (k == 12) ? 8'h3C : 8'hA5, 1'b1, 8'h00);
    chk("busy_done_pulses", done_n0, 1);
    step(1'b1, 1'b0, 8'h0F, 1'b1, 8'h00);
    idle(44);
    for (int i = 0; i < 10; i++) chk("ignored_load_bit", int'(h0[i*4]), int'(seq_a5[9-i]));
    for (int i = 0; i < 10; i++) chk("b2b_bit", int'(h0[41+i*4]), int'(seq_0f[9-i]));
    chk("b2b_busy_cycles", busy_n0, 80);
    chk("b2b_done_pulses", done_n0, 2);

    // reset at cycle 20 aborts the frame
    done_n0 = 0;
    step(1'b1, 1'b0, 8'hA5, 1'b1, 8'h00);
    idle(19);
    step(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    idle(6);
    chk("abort_no_done", done_n0, 0);
    h0.delete();
    step(1'b1, 1'b0, 8'h81, 1'b1, 8'h00);
    idle(44);
    chk("after_abort_done", done_n0, 1);
    chk("after_abort_first_data", int'(h0[4]), 1);
    chk("after_abort_last_data", int'(h0[32]), 1);

    // MSB-first, one cycle per bit
    h1.delete();
    step(1'b1, 1'b1, 8'h00, 1'b0, 8'h80);
    idle(12);
    for (int i = 0; i < 10; i++) chk("msb_first_bit", int'(h1[i]), int'(seq_80[9-i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
